alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked sequential 8-op ALU. Single-cycle ops register their
//            result on accept; DIV/MOD run an N-iteration restoring divider.
//            Optional macro ALU_FLAGS_EN adds registered zero/carry/div-by-zero
//            flag outputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic [2:0]     sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out
`ifdef ALU_FLAGS_EN
    ,
    output logic           flag_zero,
    output logic           flag_carry,
    output logic           flag_dz
`endif
);

    localparam int c_CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_DIV = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_MOD = 3'b101;
    localparam logic [2:0] c_OP_SHL = 3'b110;
    localparam logic [2:0] c_OP_SHR = 3'b111;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [2*N-1:0]  r_out;
    logic [N:0]      r_rem;
    logic [N-1:0]    r_quo;
    logic [N-1:0]    r_div_y;
    logic            r_is_mod;
    logic [c_CW-1:0] r_cnt;

    logic            w_accept;
    logic            w_is_div;
    logic [2*N-1:0]  w_xe;
    logic [2*N-1:0]  w_ye;
    logic [2*N-1:0]  w_alu;
    logic            w_carry;
    logic [N+1:0]    w_shift;
    logic [N+1:0]    w_diff;
    logic            w_ge;
    logic [N:0]      w_rem_next;
    logic [N-1:0]    w_quo_next;
    logic [2*N-1:0]  w_div_res;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;

    assign w_accept = in_valid & in_ready;
    assign w_is_div = (sel == c_OP_DIV) || (sel == c_OP_MOD);
    assign w_xe     = {{N{1'b0}}, x};
    assign w_ye     = {{N{1'b0}}, y};

    // Single-cycle result and carry flag, evaluated from the live operands
    always_comb begin
        w_alu   = '0;
        w_carry = 1'b0;
        case (sel)
            c_OP_ADD: begin
                w_alu   = w_xe + w_ye;
                w_carry = w_alu[N];
            end
            c_OP_SUB: begin
                w_alu   = w_xe - w_ye;
                w_carry = (x < y);
            end
            c_OP_MUL: w_alu = w_xe * w_ye;
            c_OP_XOR: w_alu = w_xe ^ w_ye;
            c_OP_SHL: begin
                w_alu   = w_xe << 1;
                w_carry = x[N-1];
            end
            c_OP_SHR: w_alu = w_xe >> 1;
            default:  w_alu = '0;
        endcase
    end

    // One restoring-division step: shift {rem,quo} left, trial-subtract divisor.
    // A zero divisor always succeeds, giving quotient all-ones and remainder x.
    assign w_shift    = {r_rem, r_quo[N-1]};
    assign w_diff     = w_shift - {2'b00, r_div_y};
    assign w_ge       = ~w_diff[N+1];
    assign w_rem_next = w_ge ? w_diff[N:0] : w_shift[N:0];
    assign w_quo_next = {r_quo[N-2:0], w_ge};
    assign w_div_res  = r_is_mod ? {{N{1'b0}}, w_rem_next[N-1:0]}
                                 : {{N{1'b0}}, w_quo_next};

    // Next-state logic for the IDLE/BUSY/DONE handshake sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_is_div ? S_BUSY : S_DONE;
            S_BUSY: if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

`ifdef ALU_FLAGS_EN
    logic r_flag_zero;
    logic r_flag_carry;
    logic r_flag_dz;

    assign flag_zero  = r_flag_zero;
    assign flag_carry = r_flag_carry;
    assign flag_dz    = r_flag_dz;

    // Flags are loaded on the same edges that load out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
            r_flag_dz    <= 1'b0;
        end else if (r_state == S_IDLE && w_accept && !w_is_div) begin
            r_flag_zero  <= (w_alu == '0);
            r_flag_carry <= w_carry;
            r_flag_dz    <= 1'b0;
        end else if (r_state == S_BUSY && r_cnt == '0) begin
            r_flag_zero  <= (w_div_res == '0);
            r_flag_carry <= 1'b0;
            r_flag_dz    <= (r_div_y == '0);
        end
    end
`else
    logic w_carry_unused;
    assign w_carry_unused = w_carry;
`endif

    // Datapath: result register and divider working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div_y  <= '0;
            r_is_mod <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_div) begin
                            r_rem    <= '0;
                            r_quo    <= x;
                            r_div_y  <= y;
                            r_is_mod <= (sel == c_OP_MOD);
                            r_cnt    <= c_CNT_INIT;
                        end else begin
                            r_out <= w_alu;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_cnt == '0) r_out <= w_div_res;
                    else             r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq with N=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int N = 4;

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    localparam logic [2:0] c_MUL = 3'b010;
    localparam logic [2:0] c_DIV = 3'b011;
    localparam logic [2:0] c_XOR = 3'b100;
    localparam logic [2:0] c_MOD = 3'b101;
    localparam logic [2:0] c_SHL = 3'b110;
    localparam logic [2:0] c_SHR = 3'b111;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2:0]     sel;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out;
`ifdef ALU_FLAGS_EN
    logic           flag_zero;
    logic           flag_carry;
    logic           flag_dz;
`endif

    int checks   = 0;
    int failures = 0;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef ALU_FLAGS_EN
        ,
        .flag_zero (flag_zero),
        .flag_carry(flag_carry),
        .flag_dz   (flag_dz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op from a negedge, count negedges until out_valid, check
    // latency and result, then let it drain (out_ready must be 1 here).
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2:0] op, input logic [7:0] exp, input int exp_lat);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        x = a; y = b; sel = op; in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_out"}, 32'(out), 32'(exp));
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; sel = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a division abandons it
        x = 4'd15; y = 4'd2; sel = c_DIV; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("postrst_no_result", 32'(out_valid), 32'd0);
        end

        run_op("add", 4'd15, 4'd1, c_ADD, 8'h10, 1);
`ifdef ALU_FLAGS_EN
        chk("add_flag_carry", 32'(flag_carry), 32'd1);
        chk("add_flag_zero", 32'(flag_zero), 32'd0);
`endif
        drain("add");
        run_op("sub", 4'd3, 4'd5, c_SUB, 8'hFE, 1);
`ifdef ALU_FLAGS_EN
        chk("sub_flag_carry", 32'(flag_carry), 32'd1);
`endif
        drain("sub");
        run_op("mul", 4'd15, 4'd15, c_MUL, 8'hE1, 1);
        drain("mul");
        run_op("shl", 4'd9, 4'd0, c_SHL, 8'h12, 1);
`ifdef ALU_FLAGS_EN
        chk("shl_flag_carry", 32'(flag_carry), 32'd1);
`endif
        drain("shl");
        run_op("shr", 4'd9, 4'd3, c_SHR, 8'h04, 1);
        drain("shr");
        run_op("xor", 4'd12, 4'd10, c_XOR, 8'h06, 1);
        drain("xor");
        run_op("add_zero", 4'd0, 4'd0, c_ADD, 8'h00, 1);
`ifdef ALU_FLAGS_EN
        chk("addz_flag_zero", 32'(flag_zero), 32'd1);
        chk("addz_flag_carry", 32'(flag_carry), 32'd0);
`endif
        drain("add_zero");
        run_op("div", 4'd13, 4'd4, c_DIV, 8'h03, 5);
        drain("div");
        run_op("mod", 4'd13, 4'd4, c_MOD, 8'h01, 5);
`ifdef ALU_FLAGS_EN
        chk("mod_flag_dz", 32'(flag_dz), 32'd0);
`endif
        drain("mod");
        run_op("div15_2", 4'd15, 4'd2, c_DIV, 8'h07, 5);
        drain("div15_2");
        run_op("div0", 4'd7, 4'd0, c_DIV, 8'h0F, 5);
`ifdef ALU_FLAGS_EN
        chk("div0_flag_dz", 32'(flag_dz), 32'd1);
`endif
        drain("div0");
        run_op("mod0", 4'd7, 4'd0, c_MOD, 8'h07, 5);
`ifdef ALU_FLAGS_EN
        chk("mod0_flag_dz", 32'(flag_dz), 32'd1);
`endif
        drain("mod0");

        // Backpressure: result held while the consumer stalls
        out_ready = 1'b0;
        run_op("bp", 4'd2, 4'd3, c_ADD, 8'h05, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                x = 4'd1; y = 4'd1; sel = c_MUL; in_valid = 1'b1;
            end
            @(negedge clk);
            chk("bp_out", 32'(out), 32'd5);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("bp");
        run_op("after_bp", 4'd6, 4'd3, c_SUB, 8'h03, 1);
        drain("after_bp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global timeout guard
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
